reg_write_sequencer: RTL

//  Upstream feeder for the 32x32 register-file/LED stage (JZ_4).

---
 rtl/reg_write_sequencer_if.sv | 43 ++++
 rtl/reg_write_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_sequencer_if.sv
// ---------------------------------------------------------------------------
// reg_write_sequencer_if
// Bus bundle between the switch/button front panel and the register-file
// write port.
//   Sw_Data    : byte value captured on a Load event
//   Key_Load   : raw Load push-button (asynchronous, active-high)
//   Key_Commit : raw Commit push-button (asynchronous, active-high)
//   Addr_Init  : start address, taken when Addr_Set=1 while idle
//   Addr_Set   : synchronous address-preset level
//   W_Addr     : register-file write address
//   W_Data     : register-file write data
//   Write_Reg  : single-cycle write strobe
//   Byte_Cnt   : number of bytes currently loaded (0..4)
//   Full       : all four bytes loaded
// Modports:
//   master : the sequencer, which drives the register-file write side
//   slave  : the panel/consumer side (drives keys, observes the write port)
// ---------------------------------------------------------------------------
interface reg_write_sequencer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [7:0]        Sw_Data;
    logic              Key_Load;
    logic              Key_Commit;
    logic [ADDR_W-1:0] Addr_Init;
    logic              Addr_Set;
    logic [ADDR_W-1:0] W_Addr;
    logic [DATA_W-1:0] W_Data;
    logic              Write_Reg;
    logic [2:0]        Byte_Cnt;
    logic              Full;

    modport master (
        input  Sw_Data, Key_Load, Key_Commit, Addr_Init, Addr_Set,
        output W_Addr, W_Data, Write_Reg, Byte_Cnt, Full
    );

    modport slave (
        output Sw_Data, Key_Load, Key_Commit, Addr_Init, Addr_Set,
        input  W_Addr, W_Data, Write_Reg, Byte_Cnt, Full
    );
endinterface

// File: rtl/reg_write_sequencer.sv
// ---------------------------------------------------------------------------
// reg_write_sequencer
// Builds a 32-bit register-file write word from four switch bytes. The Load
// and Commit buttons are synchronised, debounced and turned into single-cycle
// rising-edge events. Load places Sw_Data into the next free byte lane
// (little-endian, first byte in [7:0]); Commit issues one Write_Reg pulse
// with W_Addr/W_Data and then auto-increments the address.
// Ports:
//   Clk   : system clock, rising edge
//   Reset : asynchronous active-low reset
//   bus   : reg_write_sequencer_if.master (see interface header)
// ---------------------------------------------------------------------------
module reg_write_sequencer #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    reg_write_sequencer_if.master  bus
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] DB_RELOAD = CNT_W'(DEBOUNCE_CYC - 1);

    localparam int KEY_LOAD   = 0;
    localparam int KEY_COMMIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    // Insert one byte into the lane selected by the current byte count.
    function automatic logic [DATA_W-1:0] place_byte(
        input logic [DATA_W-1:0] word,
        input logic [2:0]        lane,
        input logic [7:0]        value
    );
        logic [DATA_W-1:0] res;
        res = word;
        case (lane)
            3'd0:    res[7:0]   = value;
            3'd1:    res[15:8]  = value;
            3'd2:    res[23:16] = value;
            3'd3:    res[31:24] = value;
            default: res        = word;
        endcase
        return res;
    endfunction

    // ---------------- key conditioning ----------------
    logic [1:0]       w_key_raw;
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_level;
    logic [1:0]       r_evt;
    logic [CNT_W-1:0] r_db_cnt [2];

    assign w_key_raw = {bus.Key_Commit, bus.Key_Load};

    // Synchronise, debounce and edge-detect both keys. The counter sits at
    // its reload value while the synced input agrees with the accepted level
    // and counts down while it disagrees; the level flips once the input has
    // disagreed for DEBOUNCE_CYC consecutive cycles. The event is raised in
    // the same cycle the level rises, so it is a 1-cycle 0->1 pulse.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_sync1     <= 2'b00;
            r_sync2     <= 2'b00;
            r_level     <= 2'b00;
            r_evt       <= 2'b00;
            r_db_cnt[0] <= '0;
            r_db_cnt[1] <= '0;
        end else begin
            r_sync1 <= w_key_raw;
            r_sync2 <= r_sync1;
            for (int k = 0; k < 2; k++) begin
                r_evt[k] <= 1'b0;
                if (r_sync2[k] == r_level[k]) begin
                    r_db_cnt[k] <= DB_RELOAD;
                end else if (r_db_cnt[k] == '0) begin
                    r_level[k]  <= r_sync2[k];
                    r_db_cnt[k] <= DB_RELOAD;
                    r_evt[k]    <= r_sync2[k];
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] - 1'b1;
                end
            end
        end
    end

    logic w_load_evt;
    logic w_commit_evt;
    assign w_load_evt   = r_evt[KEY_LOAD];
    assign w_commit_evt = r_evt[KEY_COMMIT];

    // ---------------- sequencer FSM ----------------
    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_data_nxt;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_nxt;
    logic              r_wr;
    logic              w_wr_nxt;
    logic              r_full;
    logic              w_full_nxt;

    // State and all outputs registered together so the write port never
    // glitches.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_cnt   <= 3'd0;
            r_wr    <= 1'b0;
            r_full  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wr    <= w_wr_nxt;
            r_full  <= w_full_nxt;
        end
    end

    // Next-state and next-output logic. Commit is tested before Load so a
    // same-cycle pair writes the existing word and drops the new byte.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_cnt_nxt   = r_cnt;
        w_wr_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.Addr_Set) begin
                    w_addr_nxt = bus.Addr_Init;
                end else begin
                    w_addr_nxt = r_addr;
                end
                // A commit with nothing loaded is ignored.
                if (w_commit_evt) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_load_evt) begin
                    w_data_nxt  = place_byte(r_data, 3'd0, bus.Sw_Data);
                    w_cnt_nxt   = 3'd1;
                    w_state_nxt = ST_FILL;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_FILL: begin
                if (w_commit_evt) begin
                    w_state_nxt = ST_WRITE;
                    w_wr_nxt    = 1'b1;
                end else if (w_load_evt) begin
                    w_data_nxt = place_byte(r_data, r_cnt, bus.Sw_Data);
                    w_cnt_nxt  = r_cnt + 3'd1;
                    if (r_cnt == 3'd3) begin
                        w_state_nxt = ST_FULL;
                    end else begin
                        w_state_nxt = ST_FILL;
                    end
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end

            ST_FULL: begin
                // Further loads are ignored: no overwrite, no wrap.
                if (w_commit_evt) begin
                    w_state_nxt = ST_WRITE;
                    w_wr_nxt    = 1'b1;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end

            ST_WRITE: begin
                // Strobe was high this cycle; clear the word and step the
                // address (wraps naturally at 2^ADDR_W). Events are dropped.
                w_state_nxt = ST_IDLE;
                w_data_nxt  = '0;
                w_cnt_nxt   = 3'd0;
                w_addr_nxt  = r_addr + 1'b1;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_data_nxt  = '0;
                w_cnt_nxt   = 3'd0;
            end
        endcase

        w_full_nxt = (w_cnt_nxt == 3'd4);
    end

    assign bus.W_Addr    = r_addr;
    assign bus.W_Data    = r_data;
    assign bus.Write_Reg = r_wr;
    assign bus.Byte_Cnt  = r_cnt;
    assign bus.Full      = r_full;

endmodule
